// File: rtl/fun_pkg.sv
// fun_pkg: widths and FSM states shared by the cube-root multiply unit.
package fun_pkg;
  localparam int A_W = 8;
  localparam int B_W = 8;
  localparam int ROOT_W = 3;
  localparam int R_W = 11;
  typedef enum logic [2:0] {IDLE, CB_MUL, CB_WAIT, CB_STEP, MUL, MUL_WAIT} state_t;
endpackage

// File: rtl/fun_mult8.sv
// mult8: 8x8->16 unsigned shift-add multiplier, one multiplier bit per cycle.
module mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o,
  output logic        done_o
);
  logic [15:0] acc_q, acc_d, mc_q, mc_d;
  logic [7:0]  mp_q, mp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  always_comb begin
    acc_d = acc_q;
    mc_d = mc_q;
    mp_d = mp_q;
    cnt_d = cnt_q;
    if (start_i) begin
      acc_d = '0;
      mc_d = {8'b0, a_i};
      mp_d = b_i;
      cnt_d = 4'd8;
    end else if (cnt_q != 4'd0) begin
      acc_d = acc_q + (mp_q[0] ? mc_q : 16'd0);
      mc_d = mc_q << 1;
      mp_d = mp_q >> 1;
      cnt_d = cnt_q - 4'd1;
    end
  end
  assign done_d = (cnt_q == 4'd1) && !start_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_q <= '0;
      mc_q <= '0;
      mp_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mc_q <= mc_d;
      mp_q <= mp_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  assign p_o = acc_q;
  assign done_o = done_q;
endmodule

// File: rtl/fun.sv
// fun: result = a * floor(cbrt(b)) via restoring cube root then multiply,
// both using one shared serial multiplier.
module fun
  import fun_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  input  logic           start,
  output logic [R_W-1:0] result,
  output logic           busy
);
  state_t              st_q, st_d;
  logic [A_W-1:0]      a_q, a_d;
  logic [B_W-1:0]      x_q, x_d;
  logic [ROOT_W-1:0]   y_q, y_d, y2;
  logic [2:0]          s_q, s_d;
  logic [R_W-1:0]      result_q, result_d;
  logic                mul_start, mul_done, ge;
  logic [7:0]          mul_a, mul_b;
  logic [15:0]         p;
  logic [23:0]         t;
  assign y2 = {y_q[ROOT_W-2:0], 1'b0};
  // trial value (3*y*(y+1)+1) << s, wide enough that no shift can overflow
  assign t = (({8'b0, p} << 1) + {8'b0, p} + 24'd1) << s_q;
  assign ge = {16'b0, x_q} >= t;
  assign mul_a = (st_q == MUL) ? a_q : {5'b0, y2};
  assign mul_b = (st_q == MUL) ? {5'b0, y_q} : {5'b0, 3'(y2 + 3'd1)};
  always_comb begin
    st_d = st_q;
    a_d = a_q;
    x_d = x_q;
    y_d = y_q;
    s_d = s_q;
    result_d = result_q;
    mul_start = 1'b0;
    case (st_q)
      IDLE: if (start) begin
        a_d = a_i;
        x_d = b_i;
        y_d = '0;
        s_d = 3'd6;
        st_d = CB_MUL;
      end
      CB_MUL: begin
        mul_start = 1'b1;
        y_d = y2;
        st_d = CB_WAIT;
      end
      CB_WAIT: st_d = mul_done ? CB_STEP : CB_WAIT;
      CB_STEP: begin
        if (ge) begin
          x_d = x_q - t[B_W-1:0];
          y_d = y_q + 3'd1;
        end
        s_d = (s_q == 3'd0) ? s_q : s_q - 3'd3;
        st_d = (s_q == 3'd0) ? MUL : CB_MUL;
      end
      MUL: begin
        mul_start = 1'b1;
        st_d = MUL_WAIT;
      end
      MUL_WAIT: if (mul_done) begin
        result_d = p[R_W-1:0];
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q <= IDLE;
      a_q <= '0;
      x_q <= '0;
      y_q <= '0;
      s_q <= '0;
      result_q <= '0;
    end else begin
      st_q <= st_d;
      a_q <= a_d;
      x_q <= x_d;
      y_q <= y_d;
      s_q <= s_d;
      result_q <= result_d;
    end
  mult8 u_mul (
    .clk(clk),
    .rst(rst),
    .start_i(mul_start),
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(p),
    .done_o(mul_done)
  );
  assign result = result_q;
  assign busy = (st_q != IDLE);
endmodule

// File: tb/tb_fun.sv
// tb_fun: directed vector table, operand sweep against a reference model,
// handshake and reset sequences for fun.
module tb_fun;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  a_i = '0, b_i = '0;
  logic        start = 1'b0;
  logic [10:0] result;
  logic        busy;
  int errs = 0, checks = 0, lat0 = -1;

  typedef struct { int a; int b; int exp; } vec_t;
  vec_t vecs [11];

  fun dut (.clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .start(start), .result(result), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int cbrt_ref(input int b);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return r;
  endfunction

  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input int a, input int b, input string name, output int lat);
    a_i = 8'(a); b_i = 8'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(lat);
    chk({name, "_done"}, int'(busy), 0);
    if (lat0 < 0) lat0 = lat;
    chk({name, "_lat"}, (lat <= 48 && lat == lat0) ? lat : -lat, lat0 <= 48 ? lat0 : -1);
  endtask

  initial begin
    int lat;
    logic [10:0] held;
    vecs = '{'{5, 27, 15}, '{3, 64, 12}, '{9, 125, 45}, '{11, 216, 66},
             '{32, 172, 160}, '{44, 255, 264}, '{84, 84, 336}, '{101, 2, 101},
             '{255, 200, 1275}, '{97, 0, 0}, '{0, 255, 0}};
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_result", int'(result), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), lat);
      chk($sformatf("vec%0d_result", i), int'(result), vecs[i].exp);
    end
    foreach (vecs[i]) chk($sformatf("vec%0d_model", i), vecs[i].a * cbrt_ref(vecs[i].b), vecs[i].exp);
    run(1, 1, "b1", lat);
    chk("b1_result", int'(result), 1);
    run(7, 215, "b215", lat);
    chk("b215_result", int'(result), 35);
    run(7, 216, "b216", lat);
    chk("b216_result", int'(result), 42);
    for (int b = 0; b < 256; b++) begin
      int a = (b * 37 + 11) & 255;
      run(a, b, $sformatf("sweep%0d", b), lat);
      chk($sformatf("sweep%0d_result", b), int'(result), a * cbrt_ref(b));
    end
    a_i = 8'd7; b_i = 8'd64; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_busy_after_start", int'(busy), 1);
    a_i = 8'd200; b_i = 8'd255;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_busy_mid", int'(busy), 1);
    wait_idle(lat);
    chk("hs_done", int'(busy), 0);
    chk("hs_ignore_result", int'(result), 28);
    held = result;
    a_i = 8'd3; b_i = 8'd250;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_hold", int'(result), int'(held));
    chk("idle_busy", int'(busy), 0);
    a_i = 8'd200; b_i = 8'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    @(posedge clk); #1;
    chk("rst_hold_busy", int'(busy), 0);
    rst = 1'b1;
    run(5, 27, "post_rst", lat);
    chk("post_rst_result", int'(result), 15);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
